cnn_residual_join: RTL and testbench



---
 rtl/cnn_residual_join.sv | 209 ++++++++++++++++++++
 tb/tb_cnn_residual_join.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_residual_join.sv
// cnn_residual_join
//   Residual merge stage of a ResNet basic block. Skip-path pixels are
//   buffered in a FIFO (optionally decimated by 2 in both dimensions for
//   downsampling blocks). Each main-path pixel pops one skip pixel, and the
//   two are added. The sum is saturated to DATA_WIDTH and optionally passed
//   through ReLU. Latency from valid_in_main to valid_out is 2 cycles.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   valid_in_skip/in_skip: skip-path pixel stream
//   valid_in_main/in_main: main-path (conv output) pixel stream
//   pxl_out/valid_out    : result pixel and strobe (pxl_out holds when idle)
//   last_out             : final pixel of a frame (only with valid_out)
//   fifo_count           : skip FIFO occupancy
//   overflow/underflow   : sticky error flags, cleared only by reset
module cnn_residual_join #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int CHANNEL_NUM  = 64,
  parameter int FIFO_DEPTH   = 1024,
  parameter int STRIDE2      = 0,
  parameter int RELU_EN      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in_skip,
  input  logic [DATA_WIDTH-1:0]           in_skip,
  input  logic                            valid_in_main,
  input  logic [DATA_WIDTH-1:0]           in_main,
  output logic [DATA_WIDTH-1:0]           pxl_out,
  output logic                            valid_out,
  output logic                            last_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int DW     = DATA_WIDTH;
  localparam int CW     = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int HW     = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int NW     = $clog2(FIFO_DEPTH+1);
  localparam int OW     = IMAGE_WIDTH  >> STRIDE2;
  localparam int OH     = IMAGE_HEIGHT >> STRIDE2;
  localparam int STAGES = 2;

  // ---------------- skip-path position counters ----------------
  logic [CW-1:0] s_col_q,  s_col_d;
  logic [RW-1:0] s_row_q,  s_row_d;
  logic [HW-1:0] s_chan_q, s_chan_d;

  always_comb begin
    s_col_d  = s_col_q;
    s_row_d  = s_row_q;
    s_chan_d = s_chan_q;
    if (valid_in_skip) begin
      if (s_col_q == CW'(IMAGE_WIDTH-1)) begin
        s_col_d = '0;
        if (s_row_q == RW'(IMAGE_HEIGHT-1)) begin
          s_row_d  = '0;
          s_chan_d = (s_chan_q == HW'(CHANNEL_NUM-1)) ? '0 : s_chan_q + 1'b1;
        end else begin
          s_row_d = s_row_q + 1'b1;
        end
      end else begin
        s_col_d = s_col_q + 1'b1;
      end
    end
  end

  // ---------------- main-path position counters ----------------
  logic [CW-1:0] m_col_q,  m_col_d;
  logic [RW-1:0] m_row_q,  m_row_d;
  logic [HW-1:0] m_chan_q, m_chan_d;
  logic          m_last;

  assign m_last = (m_col_q == CW'(OW-1)) && (m_row_q == RW'(OH-1)) &&
                  (m_chan_q == HW'(CHANNEL_NUM-1));

  always_comb begin
    m_col_d  = m_col_q;
    m_row_d  = m_row_q;
    m_chan_d = m_chan_q;
    if (valid_in_main) begin
      if (m_col_q == CW'(OW-1)) begin
        m_col_d = '0;
        if (m_row_q == RW'(OH-1)) begin
          m_row_d  = '0;
          m_chan_d = (m_chan_q == HW'(CHANNEL_NUM-1)) ? '0 : m_chan_q + 1'b1;
        end else begin
          m_row_d = m_row_q + 1'b1;
        end
      end else begin
        m_col_d = m_col_q + 1'b1;
      end
    end
  end

  // ---------------- skip FIFO ----------------
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_req, push, pop, full, empty;
  logic [DW-1:0] skip_op;

  // Decimated blocks keep only the even-row/even-column skip pixels.
  assign push_req = valid_in_skip &&
                    ((STRIDE2 == 0) || (!s_col_q[0] && !s_row_q[0]));
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == NW'(FIFO_DEPTH));
  // Pop decision uses the registered count, so a push into an empty FIFO
  // is not visible to a main pixel in the same cycle.
  assign pop      = valid_in_main && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign push     = push_req && (!full || pop);
  assign skip_op  = pop ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_q | (push_req && full && !pop);
    udf_d = udf_q | (valid_in_main && empty);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_skip;
  end

  // ---------------- datapath ----------------
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [DW:0]     sum_q, sum_d;
  logic            s1_last_q, s1_last_d;
  logic [DW-1:0]   res;
  logic [DW-1:0]   pxl_q, pxl_d;
  logic            last_q, last_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], valid_in_main};
    sum_d      = sum_q;
    s1_last_d  = s1_last_q;
    if (valid_in_main) begin
      sum_d     = {in_main[DW-1], in_main} + {skip_op[DW-1], skip_op};
      s1_last_d = m_last;
    end
  end

  // Saturate: the extra sum bit disagrees with the sign bit only on overflow.
  always_comb begin
    if (sum_q[DW] != sum_q[DW-1])
      res = sum_q[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      res = sum_q[DW-1:0];
    if ((RELU_EN != 0) && res[DW-1]) res = '0;
    pxl_d  = vld_pipe_q[1] ? res : pxl_q;
    last_d = vld_pipe_q[1] && s1_last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_col_q    <= '0;
      s_row_q    <= '0;
      s_chan_q   <= '0;
      m_col_q    <= '0;
      m_row_q    <= '0;
      m_chan_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      vld_pipe_q <= '0;
      sum_q      <= '0;
      s1_last_q  <= 1'b0;
      pxl_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      s_col_q    <= s_col_d;
      s_row_q    <= s_row_d;
      s_chan_q   <= s_chan_d;
      m_col_q    <= m_col_d;
      m_row_q    <= m_row_d;
      m_chan_q   <= m_chan_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      vld_pipe_q <= vld_pipe_d;
      sum_q      <= sum_d;
      s1_last_q  <= s1_last_d;
      pxl_q      <= pxl_d;
      last_q     <= last_d;
    end
  end

  assign pxl_out    = pxl_q;
  assign valid_out  = vld_pipe_q[STAGES];
  assign last_out   = last_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_cnn_residual_join.sv
// Directed bench for cnn_residual_join. Three instances, 16-bit 4x4x2
// frames with an 8-entry FIFO:
//   [0] STRIDE2=0 RELU_EN=0, [1] STRIDE2=0 RELU_EN=1, [2] STRIDE2=1 RELU_EN=0
module tb_cnn_residual_join;

  logic        clk;
  logic        reset;
  logic        vs [3];
  logic [15:0] sk [3];
  logic        vm [3];
  logic [15:0] mi [3];
  logic [15:0] po [3];
  logic        vo [3];
  logic        lo [3];
  logic [3:0]  fc [3];
  logic        ov [3];
  logic        un [3];

  int errs;
  int checks;

  cnn_residual_join #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM(2), .FIFO_DEPTH(8), .STRIDE2(0), .RELU_EN(0)) u_a (
    .clk(clk), .reset(reset), .valid_in_skip(vs[0]), .in_skip(sk[0]),
    .valid_in_main(vm[0]), .in_main(mi[0]), .pxl_out(po[0]), .valid_out(vo[0]),
    .last_out(lo[0]), .fifo_count(fc[0]), .overflow(ov[0]), .underflow(un[0]));

  cnn_residual_join #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM(2), .FIFO_DEPTH(8), .STRIDE2(0), .RELU_EN(1)) u_b (
    .clk(clk), .reset(reset), .valid_in_skip(vs[1]), .in_skip(sk[1]),
    .valid_in_main(vm[1]), .in_main(mi[1]), .pxl_out(po[1]), .valid_out(vo[1]),
    .last_out(lo[1]), .fifo_count(fc[1]), .overflow(ov[1]), .underflow(un[1]));

  cnn_residual_join #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM(2), .FIFO_DEPTH(8), .STRIDE2(1), .RELU_EN(0)) u_c (
    .clk(clk), .reset(reset), .valid_in_skip(vs[2]), .in_skip(sk[2]),
    .valid_in_main(vm[2]), .in_main(mi[2]), .pxl_out(po[2]), .valid_out(vo[2]),
    .last_out(lo[2]), .fifo_count(fc[2]), .overflow(ov[2]), .underflow(un[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      vs[i] = 1'b0; sk[i] = '0; vm[i] = 1'b0; mi[i] = '0;
    end
  endtask

  logic [15:0] sat_s [3];
  logic [15:0] sat_m [3];
  logic [15:0] sat_a [3];
  logic [15:0] sat_b [3];
  logic [15:0] dec_e [8];

  initial begin
    errs = 0; checks = 0;
    sat_s = '{16'h7FF0, 16'h8000, 16'h0005};
    sat_m = '{16'h0020, 16'hFFFF, 16'hFFF7};
    sat_a = '{16'h7FFF, 16'h8000, 16'hFFFC};
    sat_b = '{16'h7FFF, 16'h0000, 16'h0000};
    dec_e = '{16'd0, 16'd2, 16'd8, 16'd10, 16'd16, 16'd18, 16'd24, 16'd26};
    idle();
    reset = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_pxl",   32'(po[i]), 0);
      chk("rst_valid", 32'(vo[i]), 0);
      chk("rst_last",  32'(lo[i]), 0);
      chk("rst_count", 32'(fc[i]), 0);
      chk("rst_ovf",   32'(ov[i]), 0);
      chk("rst_udf",   32'(un[i]), 0);
    end
    reset = 1'b0;

    // basic add: skip 1..8, main 10 each -> 11..18
    for (int k = 0; k < 8; k++) begin
      vs[0] = 1'b1; sk[0] = 16'(k + 1); tick();
    end
    idle();
    chk("add_count_full", 32'(fc[0]), 8);
    for (int k = 0; k < 10; k++) begin
      vm[0] = (k < 8); mi[0] = 16'd10;
      tick();
      if (k == 0) chk("add_latency", 32'(vo[0]), 0);
      if (k >= 1 && k <= 8) begin
        chk("add_valid", 32'(vo[0]), 1);
        chk("add_pxl",   32'(po[0]), 32'(11 + k - 1));
        chk("add_last",  32'(lo[0]), 0);
      end
    end
    idle();
    chk("add_idle_valid", 32'(vo[0]), 0);
    chk("add_hold_pxl",   32'(po[0]), 18);
    chk("add_count_empty", 32'(fc[0]), 0);

    // saturation, without ([0]) and with ([1]) ReLU
    for (int k = 0; k < 3; k++) begin
      vs[0] = 1'b1; sk[0] = sat_s[k];
      vs[1] = 1'b1; sk[1] = sat_s[k];
      tick();
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      vm[0] = (k < 3); vm[1] = (k < 3);
      mi[0] = (k < 3) ? sat_m[k] : '0;
      mi[1] = mi[0];
      tick();
      if (k >= 1 && k <= 3) begin
        chk("sat_valid", 32'(vo[0]), 1);
        chk("sat_pxl",   32'(po[0]), 32'(sat_a[k-1]));
        chk("relu_valid", 32'(vo[1]), 1);
        chk("relu_pxl",  32'(po[1]), 32'(sat_b[k-1]));
      end
    end
    idle();

    // full FIFO: push+pop keeps 8, push alone overflows and drops
    for (int k = 0; k < 8; k++) begin
      vs[0] = 1'b1; sk[0] = 16'(100 + k); tick();
    end
    chk("full_count", 32'(fc[0]), 8);
    vs[0] = 1'b1; sk[0] = 16'd200; vm[0] = 1'b1; mi[0] = '0;
    tick();
    chk("full_pp_count", 32'(fc[0]), 8);
    chk("full_pp_ovf",   32'(ov[0]), 0);
    vs[0] = 1'b1; sk[0] = 16'd300; vm[0] = 1'b0;
    tick();
    chk("full_drop_ovf",   32'(ov[0]), 1);
    chk("full_drop_count", 32'(fc[0]), 8);
    chk("full_pp_pxl",     32'(po[0]), 100);
    idle();
    for (int k = 0; k < 10; k++) begin
      vm[0] = (k < 8); mi[0] = '0;
      tick();
      if (k >= 1 && k <= 8)
        chk("full_drain_pxl", 32'(po[0]), (k - 1 < 7) ? 32'(101 + k - 1) : 32'd200);
    end
    idle();
    chk("full_drain_count", 32'(fc[0]), 0);
    chk("ovf_sticky",       32'(ov[0]), 1);

    // underflow
    vm[0] = 1'b1; mi[0] = 16'd7;
    tick();
    idle();
    chk("udf_flag", 32'(un[0]), 1);
    tick();
    chk("udf_valid", 32'(vo[0]), 1);
    chk("udf_pxl",   32'(po[0]), 7);
    tick(); tick();
    chk("udf_sticky", 32'(un[0]), 1);

    // stride-2 decimation: skip 0..31 keeps even row / even col
    for (int k = 0; k < 32; k++) begin
      vs[2] = 1'b1; sk[2] = 16'(k); tick();
    end
    idle();
    chk("dec_count", 32'(fc[2]), 8);
    for (int k = 0; k < 10; k++) begin
      vm[2] = (k < 8); mi[2] = '0;
      tick();
      if (k >= 1 && k <= 8) begin
        chk("dec_valid", 32'(vo[2]), 1);
        chk("dec_pxl",   32'(po[2]), 32'(dec_e[k-1]));
        chk("dec_last",  32'(lo[2]), (k == 8) ? 32'd1 : 32'd0);
      end
    end
    idle();
    chk("dec_last_idle", 32'(lo[2]), 0);

    // reset mid-frame with 5 entries and a pixel in flight
    for (int k = 0; k < 6; k++) begin
      vs[0] = 1'b1; sk[0] = 16'(50 + k); tick();
    end
    idle();
    vm[0] = 1'b1; mi[0] = 16'd1;
    tick();
    idle();
    chk("mid_count", 32'(fc[0]), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 32'(fc[0]), 0);
    chk("mid_rst_valid", 32'(vo[0]), 0);
    chk("mid_rst_ovf",   32'(ov[0]), 0);
    chk("mid_rst_udf",   32'(un[0]), 0);
    tick();
    chk("mid_rst_flush", 32'(vo[0]), 0);

    // full frame after reset: skip k leads main by one cycle, out = 100+k
    for (int k = 0; k < 34; k++) begin
      vs[0] = (k < 32); sk[0] = 16'(k);
      vm[0] = (k >= 1 && k <= 32); mi[0] = 16'd100;
      tick();
      if (k >= 2) begin
        chk("frm_valid", 32'(vo[0]), 1);
        chk("frm_pxl",   32'(po[0]), 32'(100 + k - 2));
        chk("frm_last",  32'(lo[0]), (k == 33) ? 32'd1 : 32'd0);
      end
    end
    idle();
    chk("frm_udf", 32'(un[0]), 0);
    chk("frm_count", 32'(fc[0]), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
